// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back path: widths, requester
// identity and the holding-buffer entry format.
package regfile_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_skid_buf.sv
// One-entry write-back holding buffer. Accepts on valid & ready; the entry is
// released when the arbiter grants it, and may be refilled on that same edge.
module wb_skid_buf
    import regfile_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_rd,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    input  logic              i_grant,
    output logic              o_full,
    output logic [ADDR_W-1:0] o_rd,
    output logic [DATA_W-1:0] o_data
);

    wb_entry_t r_entry;

    // Ready while granted lets a requester sustain one write per cycle.
    assign o_ready = !i_reset && (!r_entry.valid || i_grant);
    assign o_full  = r_entry.valid;
    assign o_rd    = r_entry.rd;
    assign o_data  = r_entry.data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_entry <= '0;
        end else if (i_valid && o_ready) begin
            r_entry <= '{valid: 1'b1, rd: i_rd, data: i_data};
        end else if (i_grant) begin
            r_entry.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter between ALU and load paths, driving the
// registered register-file write port and a per-register busy scoreboard.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0]   alu_data,
    output logic                alu_ready,
    input  logic                mem_valid,
    input  logic [ADDR_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                mem_ready,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    output logic                issue_stall,
    output logic [NUM_REGS-1:0] busy,
    output logic                regWR,
    output logic [ADDR_W-1:0]   Rd,
    output logic [DATA_W-1:0]   dataWrite
);

    logic                w_alu_full;
    logic                w_mem_full;
    logic [ADDR_W-1:0]   w_alu_rd;
    logic [ADDR_W-1:0]   w_mem_rd;
    logic [DATA_W-1:0]   w_alu_data;
    logic [DATA_W-1:0]   w_mem_data;
    logic                w_grant_alu;
    logic                w_grant_mem;
    logic                w_grant;
    logic                w_win_real;
    logic [ADDR_W-1:0]   w_win_rd;
    logic [DATA_W-1:0]   w_win_data;
    logic [NUM_REGS-1:0] w_busy_next;
    logic [NUM_REGS-1:0] r_busy;
    req_e                r_last;

    wb_skid_buf u_alu_buf (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_valid (alu_valid),
        .i_rd    (alu_rd),
        .i_data  (alu_data),
        .o_ready (alu_ready),
        .i_grant (w_grant_alu),
        .o_full  (w_alu_full),
        .o_rd    (w_alu_rd),
        .o_data  (w_alu_data)
    );

    wb_skid_buf u_mem_buf (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_valid (mem_valid),
        .i_rd    (mem_rd),
        .i_data  (mem_data),
        .o_ready (mem_ready),
        .i_grant (w_grant_mem),
        .o_full  (w_mem_full),
        .o_rd    (w_mem_rd),
        .o_data  (w_mem_data)
    );

    always_comb begin
        w_grant_alu = w_alu_full && (!w_mem_full || r_last == REQ_MEM);
        w_grant_mem = w_mem_full && !w_grant_alu;
        w_grant     = w_grant_alu || w_grant_mem;
        w_win_rd    = w_grant_alu ? w_alu_rd   : w_mem_rd;
        w_win_data  = w_grant_alu ? w_alu_data : w_mem_data;
        // A granted write to the zero register is consumed without a file write.
        w_win_real  = w_grant && (w_win_rd != ZERO_REG);
    end

    // Clear first, then set, so an issue racing a retiring write stays busy.
    always_comb begin
        w_busy_next = r_busy;
        if (w_win_real) begin
            w_busy_next[w_win_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != ZERO_REG)) begin
            w_busy_next[issue_rd] = 1'b1;
        end
        w_busy_next[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_last    <= REQ_MEM;
            r_busy    <= '0;
            regWR     <= 1'b0;
            Rd        <= '0;
            dataWrite <= '0;
        end else begin
            r_busy <= w_busy_next;
            regWR  <= w_win_real;
            if (w_grant) begin
                r_last <= w_grant_alu ? REQ_ALU : REQ_MEM;
            end
            if (w_win_real) begin
                Rd        <= w_win_rd;
                dataWrite <= w_win_data;
            end
        end
    end

    assign busy        = r_busy;
    assign issue_stall = r_busy[issue_rd];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_regfile_wb_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [63:0] mem_data;
    logic        mem_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_stall;
    logic [31:0] busy;
    logic        regWR;
    logic [4:0]  Rd;
    logic [63:0] dataWrite;

    regfile_wb_arbiter dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_stall (issue_stall),
        .busy        (busy),
        .regWR       (regWR),
        .Rd          (Rd),
        .dataWrite   (dataWrite)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] d;
    } req_t;

    // Reference model: pending requests per path, who was served last, and
    // the expected scoreboard and write-port values.
    req_t        aq[$];
    req_t        mq[$];
    bit          m_last_alu;
    logic [31:0] m_busy;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [63:0] m_d;

    int          n_chk;
    int          n_pass;
    bit          acc_a;
    bit          acc_m;
    logic [4:0]  wlog[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        bit   aw;
        bit   mw;
        bit   ar;
        bit   mr;
        req_t w;
        #1;
        aw = (aq.size() != 0) && ((mq.size() == 0) || !m_last_alu);
        mw = (mq.size() != 0) && !aw;
        ar = !Reset && ((aq.size() == 0) || aw);
        mr = !Reset && ((mq.size() == 0) || mw);
        chk("alu_ready", alu_ready, ar);
        chk("mem_ready", mem_ready, mr);
        chk("issue_stall", issue_stall, m_busy[issue_rd]);
        acc_a = alu_valid && ar;
        acc_m = mem_valid && mr;
        if (Reset) begin
            aq.delete();
            mq.delete();
            m_last_alu = 1'b0;
            m_busy     = '0;
            m_we       = 1'b0;
            m_rd       = '0;
            m_d        = '0;
        end else begin
            m_we = 1'b0;
            if (aw || mw) begin
                w = aw ? aq.pop_front() : mq.pop_front();
                m_last_alu = aw;
                if (w.rd != 5'd31) begin
                    m_we = 1'b1;
                    m_rd = w.rd;
                    m_d  = w.d;
                    m_busy[w.rd] = 1'b0;
                end
            end
            if (acc_a) aq.push_back('{alu_rd, alu_data});
            if (acc_m) mq.push_back('{mem_rd, mem_data});
            if (issue_valid && issue_rd != 5'd31) m_busy[issue_rd] = 1'b1;
        end
        @(posedge Clk);
        #1;
        chk("regWR", regWR, m_we);
        if (m_we) begin
            chk("Rd", Rd, m_rd);
            chk("dataWrite", dataWrite, m_d);
            wlog.push_back(Rd);
        end
        chk("busy", busy, m_busy);
        @(negedge Clk);
    endtask

    initial begin
        int unsigned seq[8];
        int          ai;
        int          mi;
        int          hits;
        logic [4:0]  r;

        n_chk = 0;
        n_pass = 0;
        m_last_alu = 1'b0;
        m_busy = '0;
        m_we = 1'b0;
        m_rd = '0;
        m_d = '0;
        Reset = 1'b1;
        alu_valid = 1'b1;
        alu_rd = 5'd2;
        alu_data = 64'h1111;
        mem_valid = 1'b1;
        mem_rd = 5'd3;
        mem_data = 64'h2222;
        issue_valid = 1'b0;
        issue_rd = 5'd0;
        @(negedge Clk);

        // Reset held with requests pending
        repeat (3) tick();
        chk("rst_Rd", Rd, 0);
        chk("rst_dataWrite", dataWrite, 0);
        Reset = 1'b0;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        tick();

        // Contention: ALU wins the first tie after reset, then alternation
        seq = '{1, 11, 2, 12, 3, 13, 4, 14};
        wlog.delete();
        ai = 0;
        mi = 0;
        for (int c = 0; c < 30 && (ai < 4 || mi < 4 || aq.size() != 0 || mq.size() != 0); c++) begin
            alu_valid = (ai < 4);
            alu_rd    = 5'(1 + ai);
            alu_data  = 64'hA000_0000_0000_0000 | 64'(ai);
            mem_valid = (mi < 4);
            mem_rd    = 5'(11 + mi);
            mem_data  = 64'hB000_0000_0000_0000 | 64'(mi);
            tick();
            if (acc_a) ai++;
            if (acc_m) mi++;
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        chk("cont_count", wlog.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < wlog.size()) chk("cont_seq", wlog[i], seq[i]);
        end

        // Single ALU write with scoreboard set/clear
        issue_valid = 1'b1;
        issue_rd = 5'd5;
        tick();
        chk("single_busy_set", busy[5], 1);
        issue_valid = 1'b0;
        alu_valid = 1'b1;
        alu_rd = 5'd5;
        alu_data = 64'hDEAD_BEEF_0000_0001;
        tick();
        alu_valid = 1'b0;
        tick();
        chk("single_Rd", Rd, 5);
        chk("single_data", dataWrite, 64'hDEAD_BEEF_0000_0001);
        chk("single_busy_clr", busy[5], 0);

        // Zero register: consumed without a write, never busy
        alu_valid = 1'b1;
        alu_rd = 5'd31;
        alu_data = '1;
        issue_valid = 1'b1;
        issue_rd = 5'd31;
        tick();
        alu_valid = 1'b0;
        issue_valid = 1'b0;
        tick();
        chk("zero_regWR", regWR, 0);
        chk("zero_busy31", busy[31], 0);

        // Issue racing a retiring write to the same register
        alu_valid = 1'b1;
        alu_rd = 5'd7;
        alu_data = 64'h0000_0000_0000_0777;
        tick();
        alu_valid = 1'b0;
        issue_valid = 1'b1;
        issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        #1;
        chk("race_busy7", busy[7], 1);
        chk("race_stall", issue_stall, 1);
        @(negedge Clk);

        // Reset while the MEM write to r9 is still buffered
        wlog.delete();
        issue_valid = 1'b1;
        issue_rd = 5'd9;
        mem_valid = 1'b1;
        mem_rd = 5'd20;
        mem_data = 64'h20;
        tick();
        mem_valid = 1'b0;
        issue_rd = 5'd3;
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1;
        alu_rd = 5'd3;
        alu_data = 64'h33;
        mem_valid = 1'b1;
        mem_rd = 5'd9;
        mem_data = 64'h99;
        tick();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        repeat (3) tick();
        hits = 0;
        foreach (wlog[i]) if (wlog[i] == 5'd9) hits++;
        chk("midrst_no9", hits, 0);
        chk("midrst_busy", busy, 0);

        // Random traffic
        acc_a = 1'b0;
        acc_m = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!alu_valid || acc_a) begin
                alu_valid = ($urandom_range(0, 2) != 0);
                alu_rd    = 5'($urandom_range(0, 31));
                alu_data  = {$urandom, $urandom};
            end
            if (!mem_valid || acc_m) begin
                mem_valid = ($urandom_range(0, 2) != 0);
                mem_rd    = 5'($urandom_range(0, 31));
                mem_data  = {$urandom, $urandom};
            end
            r = 5'($urandom_range(0, 31));
            issue_rd = r;
            issue_valid = ($urandom_range(0, 3) == 0) && !m_busy[r];
            Reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        Reset = 1'b0;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        issue_valid = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 32×64-bit register file. It shares the file's single write port between the ALU result path and the memory load path. Each requester gets a one-entry holding buffer; the two buffers are drained round-robin, and the block drives the registered write port of the register file. A per-register busy scoreboard tells the issue stage which destinations still have writes in flight.

## Interface
- DATA_W, 64, data width of register file entries
- ADDR_W, 5, register address width
- ZERO_REG, 31, hardwired-zero register index; writes to it are consumed and never reach the file

- Clk  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU write-back request
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU buffer can accept this cycle
- mem_valid  in  1  load write-back request
- mem_rd  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  memory buffer can accept this cycle
- issue_valid  in  1  an instruction with a destination issues this cycle
- issue_rd  in  ADDR_W  destination of the issuing instruction
- issue_stall  out  1  combinational; high when issue_rd is busy
- busy  out  32  scoreboard; bit i = write to register i pending
- regWR  out  1  registered write enable to register file
- Rd  out  ADDR_W  registered write address
- dataWrite  out  DATA_W  registered write data

## Operation
- Handshake: a transfer occurs when valid & ready on a rising edge; the request is captured into that requester's buffer. valid must not depend on ready.
- ready = !Reset & (buffer empty | buffer granted this cycle). Result: 1 write/cycle sustained per requester when uncontended.
- Arbitration (combinational on buffer-full flags):
  - Only one buffer full: it wins.
  - Both full: winner is the requester not granted last; `last` updates on every grant.
  - After reset, `last` = MEM, so the ALU wins the first tie.
- Grant: the winning buffer empties at the edge. The same edge registers regWR=1, Rd, and dataWrite. With no grant, regWR=0 and Rd/dataWrite hold their values.
- ZERO_REG: a granted entry with rd==ZERO_REG empties its buffer but registers regWR=0. It still consumes the grant and updates `last`.
- Scoreboard:
  - issue_valid with issue_rd≠ZERO_REG sets busy[issue_rd].
  - A granted write to rd≠ZERO_REG clears busy[rd].
  - Set and clear of the same index on the same edge: set wins.
  - busy[ZERO_REG] is always 0.
- The issue stage must not assert issue_valid while issue_stall=1. The bench asserts this rule; RTL behaviour when it is violated is a don't-care.
- Widths: no arithmetic on data; dataWrite is a pure copy of the buffered data.

## Timing
- Reset values: regWR=0, Rd=0, dataWrite=0, busy=0, both buffers empty, last=MEM, alu_ready=mem_ready=0 while Reset=1.
- Reset mid-operation: buffered, ungranted writes are dropped; scoreboard is cleared.
- Latency, with acceptance at edge N:
  - Uncontended: the write is presented on regWR/Rd/dataWrite after edge N+1. The file commits it on the falling edge of that cycle, and busy[rd] reads 0 from edge N+1.
  - Contended: the losing requester's write is delayed by one cycle per earlier grant, worst case N+2.
- Simultaneous accept on both paths to the same rd: both writes are performed, ALU/MEM order per round-robin. Ordering is the pipeline's responsibility, guaranteed by the issue_stall rule.
- All outputs except issue_stall and the ready signals are registered.

## Structure
- Shared package `regfile_pkg`:
  - DATA_W, ADDR_W, NUM_REGS=32, ZERO_REG.
  - Requester enum {REQ_ALU, REQ_MEM}.
  - Buffer entry struct {valid, rd, data}.
- Sub-module `wb_skid_buf` is instantiated twice. It is a one-entry buffer with a valid/ready input side and full/data/grant on the output side.
- Top-level logic: round-robin select, registered write port, and scoreboard vector.

## Test plan
- Reset: hold Reset 3 cycles with valids high → regWR=0, busy=0, alu_ready=mem_ready=0. After release, alu_ready=mem_ready=1.
- Single ALU write: issue rd=5, then alu rd=5, data=64'hDEAD_BEEF_0000_0001 → next cycle regWR=1, Rd=5, dataWrite matches, busy[5] 1→0 at that edge.
- Contention: both valid every cycle, alu rd=1..4, mem rd=11..14 → Rd sequence 1,11,2,12,3,13,4,14. Throughput is one write per cycle; each ready toggles to stall every other cycle.
- ZERO_REG: alu rd=31, data=all ones → buffer drains, regWR stays 0, busy[31]=0; issue rd=31 never sets busy.
- Scoreboard race: issue_rd=7 on the same edge as a granted write to 7 → busy[7]=1 afterwards. issue_stall=1 when issue_rd=7 is presented.
- Reset mid-flight: accept mem rd=9 and alu rd=3 with ALU granted; assert Reset before the MEM grant → no write to 9 occurs, busy=0.
